// File: rtl/range_tracker.sv
// range_tracker: tracks min/max/count of valid samples over a go..finish sequence and reports range = max - min.
module range_tracker #(
  parameter int WIDTH = 8,
  parameter int CNT_WIDTH = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     range,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     max_out,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done,
  output logic                 error
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] mn, mx, nmn, nmx;
  logic [CNT_WIDTH-1:0] cnt, ncnt;
  logic lt_min, gt_max, full, start;
  always_comb begin
    lt_min = SIGNED ? ($signed(data_in) < $signed(mn)) : (data_in < mn);
    gt_max = SIGNED ? ($signed(data_in) > $signed(mx)) : (data_in > mx);
    nmn = (valid && lt_min) ? data_in : mn;
    nmx = (valid && gt_max) ? data_in : mx;
    ncnt = cnt + CNT_WIDTH'(valid);
    full = cnt == '1;
    start = go && !finish;
  end
  assign error = state == ERR;
  // IDLE and ERROR share the restart rule; only IDLE reaches ERROR via finish, ERROR just stays
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mn <= '0;
      mx <= '0;
      cnt <= '0;
      range <= '0;
      min_out <= '0;
      max_out <= '0;
      count <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != RUN) begin
        if (start) begin
          mn <= data_in;
          mx <= data_in;
          cnt <= CNT_WIDTH'(1);
          state <= RUN;
        end else if (finish) state <= ERR;
      end else if (go || (valid && full)) state <= ERR;
      else begin
        mn <= nmn;
        mx <= nmx;
        cnt <= ncnt;
        if (finish) begin
          range <= nmx - nmn;
          min_out <= nmn;
          max_out <= nmx;
          count <= ncnt;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_range_tracker.sv
// tb_range_tracker: drives an unsigned and a signed/3-bit-counter instance with identical stimulus against a sample-queue model.
module tb_range_tracker;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] data_in = '0;
  logic valid = 1'b0, go = 1'b0, finish = 1'b0;
  logic [7:0] r0, mn0, mx0, c0, r1, mn1, mx1;
  logic [2:0] c1;
  logic d0, e0, d1, e1;
  int checks = 0, errors = 0;
  int mode[2];
  int q0[$], q1[$];
  logic [31:0] e_rng[2], e_min[2], e_max[2], e_cnt[2];
  logic e_done[2];

  range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED(1'b0)) u_u (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid), .go(go), .finish(finish),
    .range(r0), .min_out(mn0), .max_out(mx0), .count(c0), .done(d0), .error(e0));
  range_tracker #(.WIDTH(8), .CNT_WIDTH(3), .SIGNED(1'b1)) u_s (
    .clock(clock), .reset(reset), .data_in(data_in), .valid(valid), .go(go), .finish(finish),
    .range(r1), .min_out(mn1), .max_out(mx1), .count(c1), .done(d1), .error(e1));

  always #5 clock = ~clock;

  function automatic int sv(int k, logic [7:0] x);
    return k ? int'($signed(x)) : int'(x);
  endfunction

  // mode: 0 idle, 1 collecting, 2 error; results computed from the whole sample list at finish
  task automatic mstep(int k);
    int cur[$];
    int lo, hi, cmax;
    cur = (k == 0) ? q0 : q1;
    cmax = (k == 0) ? 255 : 7;
    e_done[k] = 1'b0;
    if (reset) begin
      mode[k] = 0;
      cur = {};
      e_rng[k] = 0; e_min[k] = 0; e_max[k] = 0; e_cnt[k] = 0;
    end else if (mode[k] != 1) begin
      if (go && !finish) begin
        mode[k] = 1;
        cur = {sv(k, data_in)};
      end else if (finish) mode[k] = 2;
    end else if (go || (valid && cur.size() == cmax)) mode[k] = 2;
    else begin
      if (valid) cur.push_back(sv(k, data_in));
      if (finish) begin
        lo = cur[0];
        hi = cur[0];
        foreach (cur[i]) begin
          if (cur[i] < lo) lo = cur[i];
          if (cur[i] > hi) hi = cur[i];
        end
        e_rng[k] = (hi - lo) & 255;
        e_min[k] = lo & 255;
        e_max[k] = hi & 255;
        e_cnt[k] = cur.size();
        e_done[k] = 1'b1;
        mode[k] = 0;
      end
    end
    if (k == 0) q0 = cur; else q1 = cur;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("u_range", r0, e_rng[0]); chk("u_min", mn0, e_min[0]); chk("u_max", mx0, e_max[0]);
    chk("u_count", c0, e_cnt[0]); chk("u_done", d0, e_done[0]); chk("u_error", e0, mode[0] == 2);
    chk("s_range", r1, e_rng[1]); chk("s_min", mn1, e_min[1]); chk("s_max", mx1, e_max[1]);
    chk("s_count", c1, e_cnt[1]); chk("s_done", d1, e_done[1]); chk("s_error", e1, mode[1] == 2);
  endtask

  task automatic cyc(bit r, bit g, bit f, bit v, logic [7:0] d);
    reset = r; go = g; finish = f; valid = v; data_in = d;
    @(posedge clock);
    mstep(0);
    mstep(1);
    #1;
    check_all();
  endtask

  initial begin
    cyc(1, 0, 0, 0, 8'd0);
    cyc(1, 1, 0, 1, 8'd99);
    chk("rst_range", r0, 0); chk("rst_count", c0, 0); chk("rst_error", e0, 0); chk("rst_done", d0, 0);
    // unsigned example
    cyc(0, 1, 0, 0, 8'd10);
    cyc(0, 0, 0, 1, 8'd3);
    cyc(0, 0, 0, 1, 8'd200);
    cyc(0, 0, 0, 1, 8'd45);
    cyc(0, 0, 1, 1, 8'd7);
    chk("ex1_range", r0, 197); chk("ex1_min", mn0, 3); chk("ex1_max", mx0, 200);
    chk("ex1_count", c0, 5); chk("ex1_done", d0, 1);
    cyc(0, 0, 0, 0, 8'd0);
    chk("ex1_done_drop", d0, 0);
    // signed example
    cyc(0, 1, 0, 0, 8'hFB);
    cyc(0, 0, 0, 1, 8'd20);
    cyc(0, 0, 0, 1, 8'h9C);
    cyc(0, 0, 1, 0, 8'd0);
    chk("ex2_range", r1, 120); chk("ex2_min", mn1, 8'h9C); chk("ex2_max", mx1, 8'h14);
    chk("ex2_count", c1, 3); chk("ex2_done", d1, 1);
    // protocol errors
    cyc(0, 0, 1, 0, 8'd0);
    chk("idle_finish_err", e0, 1);
    cyc(0, 1, 0, 0, 8'd50);
    chk("err_restart", e0, 0);
    cyc(0, 1, 0, 1, 8'd60);
    chk("run_go_err", e0, 1); chk("run_go_hold", r1, 120); chk("run_go_nodone", d1, 0);
    cyc(0, 1, 1, 0, 8'd1);
    chk("err_gofin_stay", e0, 1);
    // gaps
    cyc(0, 1, 0, 0, 8'd100);
    cyc(0, 0, 0, 1, 8'd90);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 8'($urandom));
    cyc(0, 0, 1, 1, 8'd130);
    chk("gap_count", c0, 3); chk("gap_range", r0, 40);
    cyc(0, 1, 1, 0, 8'd5);
    chk("post_fin_gofin_err", e0, 1);
    // overflow on the 3-bit counter instance
    cyc(0, 1, 0, 0, 8'd1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 8'(i + 2));
    chk("ovf_err", e1, 1); chk("ovf_no_err_u", e0, 0); chk("ovf_count_hold", c1, e_cnt[1]);
    cyc(0, 0, 1, 1, 8'd9);
    chk("ovf_err_stays", e1, 1); chk("ovf_s_nodone", d1, 0); chk("ovf_u_count", c0, 9);
    // single sample
    cyc(0, 1, 0, 0, 8'd77);
    cyc(0, 0, 1, 0, 8'd0);
    chk("single_range", r0, 0); chk("single_min", mn0, 77); chk("single_count", c0, 1);
    // reset mid-run
    cyc(0, 1, 0, 0, 8'd4);
    cyc(0, 0, 0, 1, 8'd8);
    cyc(1, 0, 0, 1, 8'd8);
    chk("mid_rst_range", r0, 0); chk("mid_rst_count", c0, 0); chk("mid_rst_err", e0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, 8'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
